// File: rtl/demux1to16_pkt_pkg.sv
package demux1to16_pkt_pkg;

  localparam int unsigned DMX_DATA_WIDTH = 32;
  localparam int unsigned DMX_PORT_NUM   = 16;
  localparam int unsigned DMX_LEN_WIDTH  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } dmx_state_e;

endpackage

// File: rtl/demux1to16_pkt_if.sv
// Beat stream in, per-port beat streams out. The master drives the input
// stream and observes the ports; the slave is the dispatcher itself.
interface demux1to16_pkt_if
   import demux1to16_pkt_pkg::*;
#(
   parameter int unsigned PORT_NUM   = DMX_PORT_NUM,
   parameter int unsigned DATA_WIDTH = DMX_DATA_WIDTH
) ();

   localparam int unsigned DEST_W = $clog2(PORT_NUM);

   logic                                 i_wr_sop;
   logic                                 i_wr_eop;
   logic                                 i_wr_vld;
   logic [DEST_W-1:0]                    i_wr_dest;
   logic [DATA_WIDTH-1:0]                i_wr_data;

   logic [PORT_NUM-1:0]                  o_wr_sop;
   logic [PORT_NUM-1:0]                  o_wr_eop;
   logic [PORT_NUM-1:0]                  o_wr_vld;
   logic [PORT_NUM-1:0][DATA_WIDTH-1:0]  o_wr_data;

   modport master (
      output i_wr_sop, i_wr_eop, i_wr_vld, i_wr_dest, i_wr_data,
      input  o_wr_sop, o_wr_eop, o_wr_vld, o_wr_data
   );

   modport slave (
      input  i_wr_sop, i_wr_eop, i_wr_vld, i_wr_dest, i_wr_data,
      output o_wr_sop, o_wr_eop, o_wr_vld, o_wr_data
   );

endinterface

// File: rtl/demux1to16_pkt.sv
// Packet-aware 1-to-N write dispatcher: steers each whole packet to the port
// named by the destination sampled at sop. Outputs are registered (1-cycle
// latency); framing errors produce a single-cycle o_err pulse.
module demux1to16_pkt
   import demux1to16_pkt_pkg::*;
#(
   parameter int unsigned PORT_NUM   = DMX_PORT_NUM,
   parameter int unsigned DATA_WIDTH = DMX_DATA_WIDTH,
   parameter int unsigned LEN_WIDTH  = DMX_LEN_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_en,
   demux1to16_pkt_if.slave       wr,
   output logic                  o_busy,
   output logic                  o_err,
   output logic [LEN_WIDTH-1:0]  o_pkt_len
);

   localparam int unsigned DEST_W = $clog2(PORT_NUM);

   dmx_state_e                           state_q, state_d;
   logic [DEST_W-1:0]                    dest_q, dest_d;
   logic [LEN_WIDTH-1:0]                 cnt_q, cnt_d, cnt_inc, len_d;
   logic                                 err_d;
   logic                                 fwd;
   logic [DEST_W-1:0]                    fwd_dest;

   logic [PORT_NUM-1:0]                  vld_d, sop_d, eop_d;
   logic [PORT_NUM-1:0][DATA_WIDTH-1:0]  data_d;

   // Beat counter saturates at all-ones instead of wrapping.
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + LEN_WIDTH'(1);

   assign o_busy = (state_q == PKT);

   // FSM, dest latch, counter and pkt_len registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         dest_q    <= '0;
         cnt_q     <= '0;
         o_pkt_len <= '0;
         o_err     <= 1'b0;
      end else begin
         state_q   <= state_d;
         dest_q    <= dest_d;
         cnt_q     <= cnt_d;
         o_pkt_len <= len_d;
         o_err     <= err_d;
      end
   end

   // Next-state, forwarding decision and framing-error detection.
   always_comb begin
      state_d  = state_q;
      dest_d   = dest_q;
      cnt_d    = cnt_q;
      len_d    = o_pkt_len;
      err_d    = 1'b0;
      fwd      = 1'b0;
      fwd_dest = dest_q;
      if (wr.i_wr_vld) begin
         if (wr.i_wr_sop) begin
            // A sop inside an open packet abandons it and restarts with this
            // beat as a fresh sop; i_en only gates packets started from IDLE.
            if (state_q == PKT) err_d = 1'b1;
            if (i_en || (state_q == PKT)) begin
               fwd      = 1'b1;
               fwd_dest = wr.i_wr_dest;
               dest_d   = wr.i_wr_dest;
               cnt_d    = LEN_WIDTH'(1);
               if (wr.i_wr_eop) begin
                  len_d   = LEN_WIDTH'(1);
                  state_d = IDLE;
               end else begin
                  state_d = PKT;
               end
            end
         end else if (state_q == PKT) begin
            fwd   = 1'b1;
            cnt_d = cnt_inc;
            if (wr.i_wr_eop) begin
               len_d   = cnt_inc;
               state_d = IDLE;
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // One-hot steering of the forwarded beat; unselected ports stay all-zero.
   always_comb begin
      vld_d  = '0;
      sop_d  = '0;
      eop_d  = '0;
      data_d = '0;
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
         if (fwd && (fwd_dest == DEST_W'(p))) begin
            vld_d[p]  = 1'b1;
            sop_d[p]  = wr.i_wr_sop;
            eop_d[p]  = wr.i_wr_eop;
            data_d[p] = wr.i_wr_data;
         end
      end
   end

   // Registered per-port outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr.o_wr_vld  <= '0;
         wr.o_wr_sop  <= '0;
         wr.o_wr_eop  <= '0;
         wr.o_wr_data <= '0;
      end else begin
         wr.o_wr_vld  <= vld_d;
         wr.o_wr_sop  <= sop_d;
         wr.o_wr_eop  <= eop_d;
         wr.o_wr_data <= data_d;
      end
   end

endmodule

// File: tb/tb_demux1to16_pkt.sv
// Directed bench for demux1to16_pkt: framing, routing, error pulses, reset.
module tb_demux1to16_pkt;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        busy;
   logic        err;
   logic [15:0] pkt_len;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0]        ev, es, ee;
   logic [15:0][31:0]  ed;

   demux1to16_pkt_if #(.PORT_NUM(16), .DATA_WIDTH(32)) bus ();

   demux1to16_pkt #(.PORT_NUM(16), .DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_en      (en),
      .wr        (bus),
      .o_busy    (busy),
      .o_err     (err),
      .o_pkt_len (pkt_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one beat, let it be clocked, then settle just past the edge.
   task automatic drive(input logic v, input logic s, input logic e,
                        input logic [3:0] d, input logic [31:0] dat);
      bus.i_wr_vld  = v;
      bus.i_wr_sop  = s;
      bus.i_wr_eop  = e;
      bus.i_wr_dest = d;
      bus.i_wr_data = dat;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b1;
      bus.i_wr_vld = 1'b0; bus.i_wr_sop = 1'b0; bus.i_wr_eop = 1'b0;
      bus.i_wr_dest = '0;  bus.i_wr_data = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({bus.o_wr_vld, bus.o_wr_sop, bus.o_wr_eop} !== 48'h0) begin
         n_fail++; $display("FAIL reset_ctl got %h want 0", {bus.o_wr_vld, bus.o_wr_sop, bus.o_wr_eop});
      end
      n_checks++;
      if (bus.o_wr_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.o_wr_data); end
      n_checks++;
      if ({busy, err} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_err got %b want 00", {busy, err}); end
      n_checks++;
      if (pkt_len !== 16'd0) begin n_fail++; $display("FAIL reset_len got %0d want 0", pkt_len); end
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_packet();
      for (int i = 0; i < 4; i++) begin
         // dest varies after sop and must be ignored
         drive(1, i == 0, i == 3, (i == 0) ? 4'd5 : 4'(i), 32'hA000_0000 + i);
         ev = 16'h0020;
         es = (i == 0) ? ev : 16'h0;
         ee = (i == 3) ? ev : 16'h0;
         ed = '0; ed[5] = 32'hA000_0000 + i;
         n_checks++;
         if ({bus.o_wr_vld, bus.o_wr_sop, bus.o_wr_eop} !== {ev, es, ee}) begin
            n_fail++; $display("FAIL pkt_ctl beat %0d got %h want %h", i, {bus.o_wr_vld, bus.o_wr_sop, bus.o_wr_eop}, {ev, es, ee});
         end
         n_checks++;
         if (bus.o_wr_data !== ed) begin n_fail++; $display("FAIL pkt_data beat %0d got %h want %h", i, bus.o_wr_data, ed); end
         n_checks++;
         if ({busy, err} !== {(i < 3), 1'b0}) begin
            n_fail++; $display("FAIL pkt_busy_err beat %0d got %b want %b", i, {busy, err}, {(i < 3), 1'b0});
         end
      end
      n_checks++;
      if (pkt_len !== 16'd4) begin n_fail++; $display("FAIL pkt_len got %0d want 4", pkt_len); end
      drive(0, 0, 0, 0, 0);
      n_checks++;
      if (bus.o_wr_vld !== 16'h0) begin n_fail++; $display("FAIL pkt_idle_vld got %h want 0", bus.o_wr_vld); end
   endtask

   task automatic test_single_beat();
      drive(1, 1, 1, 4'd15, 32'h0000_00B5);
      ev = 16'h8000;
      ed = '0; ed[15] = 32'h0000_00B5;
      n_checks++;
      if ({bus.o_wr_vld, bus.o_wr_sop, bus.o_wr_eop} !== {ev, ev, ev}) begin
         n_fail++; $display("FAIL single_ctl got %h want %h", {bus.o_wr_vld, bus.o_wr_sop, bus.o_wr_eop}, {ev, ev, ev});
      end
      n_checks++;
      if (bus.o_wr_data !== ed) begin n_fail++; $display("FAIL single_data got %h want %h", bus.o_wr_data, ed); end
      n_checks++;
      if ({busy, pkt_len} !== {1'b0, 16'd1}) begin
         n_fail++; $display("FAIL single_busy_len got %b/%0d want 0/1", busy, pkt_len);
      end
      drive(0, 0, 0, 0, 0);
      n_checks++;
      if ({bus.o_wr_vld, busy} !== 17'h0) begin n_fail++; $display("FAIL single_after got %h want 0", {bus.o_wr_vld, busy}); end
   endtask

   task automatic test_orphan();
      drive(1, 0, 0, 4'd3, 32'h0000_00C3);
      n_checks++;
      if (bus.o_wr_vld !== 16'h0) begin n_fail++; $display("FAIL orphan_vld got %h want 0", bus.o_wr_vld); end
      n_checks++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL orphan_err got %b want 1", err); end
      drive(0, 0, 0, 0, 0);
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL orphan_err_clear got %b want 0", err); end
   endtask

   task automatic test_abandon();
      for (int i = 0; i < 3; i++) begin
         drive(1, i == 0, 0, 4'd2, 32'h0000_0D00 + i);
         n_checks++;
         if (bus.o_wr_vld !== 16'h0004) begin n_fail++; $display("FAIL abandon_p2 beat %0d got %h want 0004", i, bus.o_wr_vld); end
      end
      drive(1, 1, 0, 4'd7, 32'h0000_0D70);
      n_checks++;
      if ({bus.o_wr_vld, bus.o_wr_sop, bus.o_wr_eop} !== {16'h0080, 16'h0080, 16'h0}) begin
         n_fail++; $display("FAIL abandon_newsop got %h want %h", {bus.o_wr_vld, bus.o_wr_sop, bus.o_wr_eop}, {16'h0080, 16'h0080, 16'h0});
      end
      n_checks++;
      if ({err, busy, pkt_len} !== {1'b1, 1'b1, 16'd1}) begin
         n_fail++; $display("FAIL abandon_err got err=%b busy=%b len=%0d want 1/1/1", err, busy, pkt_len);
      end
      drive(1, 0, 1, 4'd2, 32'h0000_0D71);
      ed = '0; ed[7] = 32'h0000_0D71;
      n_checks++;
      if ({bus.o_wr_vld, bus.o_wr_sop, bus.o_wr_eop} !== {16'h0080, 16'h0, 16'h0080}) begin
         n_fail++; $display("FAIL abandon_eop got %h want %h", {bus.o_wr_vld, bus.o_wr_sop, bus.o_wr_eop}, {16'h0080, 16'h0, 16'h0080});
      end
      n_checks++;
      if (bus.o_wr_data !== ed) begin n_fail++; $display("FAIL abandon_data got %h want %h", bus.o_wr_data, ed); end
      n_checks++;
      if ({err, busy, pkt_len} !== {1'b0, 1'b0, 16'd2}) begin
         n_fail++; $display("FAIL abandon_len got err=%b busy=%b len=%0d want 0/0/2", err, busy, pkt_len);
      end
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_enable();
      en = 1'b0;
      drive(1, 1, 1, 4'd4, 32'h0000_0E41);
      n_checks++;
      if ({bus.o_wr_vld, err, busy} !== 18'h0) begin n_fail++; $display("FAIL en_drop_single got %h want 0", {bus.o_wr_vld, err, busy}); end
      drive(1, 1, 0, 4'd4, 32'h0000_0E42);
      n_checks++;
      if ({bus.o_wr_vld, err, busy} !== 18'h0) begin n_fail++; $display("FAIL en_drop_sop got %h want 0", {bus.o_wr_vld, err, busy}); end
      drive(0, 0, 0, 0, 0);
      en = 1'b1;
      drive(1, 1, 0, 4'd9, 32'h0000_0E90);
      en = 1'b0;
      drive(1, 0, 0, 4'd9, 32'h0000_0E91);
      n_checks++;
      if (bus.o_wr_vld !== 16'h0200) begin n_fail++; $display("FAIL en_mid_vld got %h want 0200", bus.o_wr_vld); end
      drive(1, 0, 1, 4'd9, 32'h0000_0E92);
      ed = '0; ed[9] = 32'h0000_0E92;
      n_checks++;
      if ({bus.o_wr_vld, bus.o_wr_eop} !== {16'h0200, 16'h0200}) begin
         n_fail++; $display("FAIL en_mid_eop got %h want 02000200", {bus.o_wr_vld, bus.o_wr_eop});
      end
      n_checks++;
      if (bus.o_wr_data !== ed) begin n_fail++; $display("FAIL en_mid_data got %h want %h", bus.o_wr_data, ed); end
      n_checks++;
      if ({err, pkt_len} !== {1'b0, 16'd3}) begin n_fail++; $display("FAIL en_mid_len got err=%b len=%0d want 0/3", err, pkt_len); end
      en = 1'b1;
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_saturation();
      drive(1, 1, 0, 4'd1, 32'h1);
      for (int i = 0; i < 65536; i++) drive(1, 0, 0, 4'd1, 32'h2);
      drive(1, 0, 1, 4'd1, 32'h3);
      n_checks++;
      if ({bus.o_wr_eop, busy, pkt_len} !== {16'h0002, 1'b0, 16'hFFFF}) begin
         n_fail++; $display("FAIL sat_len got eop=%h busy=%b len=%h want 0002/0/ffff", bus.o_wr_eop, busy, pkt_len);
      end
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset_mid_packet();
      drive(1, 1, 0, 4'd11, 32'h0000_0F00);
      drive(1, 0, 0, 4'd11, 32'h0000_0F01);
      n_checks++;
      if (bus.o_wr_vld !== 16'h0800) begin n_fail++; $display("FAIL rstmid_pre got %h want 0800", bus.o_wr_vld); end
      bus.i_wr_vld = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({bus.o_wr_vld, busy, pkt_len} !== 33'h0) begin
         n_fail++; $display("FAIL rstmid_ctl got vld=%h busy=%b len=%0d want 0", bus.o_wr_vld, busy, pkt_len);
      end
      n_checks++;
      if (bus.o_wr_data !== '0) begin n_fail++; $display("FAIL rstmid_data got %h want 0", bus.o_wr_data); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1, 0, 0, 4'd11, 32'h0000_0F02);
      n_checks++;
      if ({bus.o_wr_vld, err} !== {16'h0, 1'b1}) begin n_fail++; $display("FAIL rstmid_orphan1 got %h want 00001", {bus.o_wr_vld, err}); end
      drive(1, 0, 1, 4'd11, 32'h0000_0F03);
      n_checks++;
      if ({bus.o_wr_vld, err} !== {16'h0, 1'b1}) begin n_fail++; $display("FAIL rstmid_orphan2 got %h want 00001", {bus.o_wr_vld, err}); end
      drive(1, 1, 0, 4'd0, 32'h0000_0A00);
      n_checks++;
      if ({bus.o_wr_vld, bus.o_wr_sop, err} !== {16'h0001, 16'h0001, 1'b0}) begin
         n_fail++; $display("FAIL rstmid_p0_sop got %h want %h", {bus.o_wr_vld, bus.o_wr_sop, err}, {16'h0001, 16'h0001, 1'b0});
      end
      drive(1, 0, 1, 4'd6, 32'h0000_0A01);
      ed = '0; ed[0] = 32'h0000_0A01;
      n_checks++;
      if ({bus.o_wr_eop, pkt_len} !== {16'h0001, 16'd2}) begin
         n_fail++; $display("FAIL rstmid_p0_eop got eop=%h len=%0d want 0001/2", bus.o_wr_eop, pkt_len);
      end
      n_checks++;
      if (bus.o_wr_data !== ed) begin n_fail++; $display("FAIL rstmid_p0_data got %h want %h", bus.o_wr_data, ed); end
      drive(0, 0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_packet();
      test_single_beat();
      test_orphan();
      test_abandon();
      test_enable();
      test_saturation();
      test_reset_mid_packet();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL timeout: bench did not complete, %0d checks done", n_checks);
      $fatal(1);
   end

endmodule
